uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front end for the femtoRV SOC. It sits between the RXD pad and the SOC's memory-mapped IO bus.
- Recovers 8N1 UART frames from the asynchronous RXD line and buffers received bytes in a small FIFO.
- The CPU pops bytes through a one-cycle read strobe from the IO decode logic.
- Reports framing errors and overruns as sticky flags.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division. Must be >= 8.
- FIFO_DEPTH, 8, number of byte entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- rxd  in  1  raw serial input, asynchronous to clk, idle high.
- rd_en  in  1  pop strobe; one byte consumed per cycle high while rx_valid=1.
- rd_data  out  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a complete byte was dropped because the FIFO was full.
- clr_flags  in  1  clears frame_err and overrun for one cycle.

Behaviour:
- Reset state:
  - Synchronizer flops = 1.
  - FSM = IDLE; bit and baud counters = 0.
  - FIFO empty: rx_valid=0, rd_data=0.
  - frame_err=0, overrun=0.
- Reset is asynchronous. Asserting it mid-frame abandons the partial byte and empties the FIFO.
- Input path: rxd passes through a 2-flop synchronizer to give rxs. Nothing else reads raw rxd.
- FSM states:
  - IDLE: when rxs=0, load baud counter with CLKS_PER_BIT/2 - 1 and go to START.
  - START: when the counter reaches 0, sample rxs.
    - rxs=1 is a glitch: return to IDLE, push nothing, set no flag.
    - rxs=0: go to DATA with bit index 0 and counter CLKS_PER_BIT-1.
  - DATA: at each counter expiry, shift rxs into the shift register LSB-first and reload the counter. After bit 7 go to STOP.
  - STOP: at counter expiry, sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: discard the byte, set frame_err, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. A held-low break line produces exactly one frame_err and no bytes.
- FIFO push timing: the push happens in the cycle after the stop-bit sample. rx_valid rises in the following cycle. Latency from rxd falling edge to rx_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles, ±1.
- FIFO read:
  - rd_data is the head entry, read combinationally from registered storage.
  - The pop takes effect at the clock edge where rd_en=1 and rx_valid=1.
  - rd_en while empty is ignored; pointers are unchanged.
- Full handling:
  - Push while full with no pop in the same cycle: drop the byte and set overrun. Stored contents are unchanged.
  - Push and pop in the same cycle while full: both happen, count stays at FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle while non-empty: count is unchanged.
- Pointers: log2(FIFO_DEPTH) bits wide, wrapping naturally, plus a count register of log2(FIFO_DEPTH)+1 bits.
- Flags: clr_flags clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- The receiver keeps running while the FIFO is full. Overrun only loses the newest byte.

Decomposition:
- Shared include file, used by the SOC IO decode:
  - FSM state encodings: IDLE, START, DATA, STOP, WAIT_HIGH (3 bits).
  - IO register offsets: RX data, RX status.
  - Status bit positions: valid=0, frame_err=1, overrun=2.
- One sub-module: sync_fifo (parameter WIDTH=8 and DEPTH), with push, pop, full, empty, head outputs. The future uart_tx path reuses it.
- Synchronizer and FSM live in uart_rx_fifo.

Test Plan:
Bench uses CLK_HZ=1600000 and BAUD=100000, giving CLKS_PER_BIT=16.
- Single frame 0xA5, 8N1 -> rx_valid rises about 150 cycles after the start edge, rd_data=0xA5. A pulse on rd_en -> rx_valid=0 the next cycle.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> all three read in order, frame_err=0, overrun=0.
- 4-cycle low glitch on rxd from idle -> no push, no flags, FSM back in IDLE before cycle 12.
- Frame 0x55 with the stop bit driven low -> no byte pushed, frame_err=1. rxd held low 40 more bit times -> still exactly one error and no pushes. clr_flags -> frame_err=0.
- Nine frames 0x01..0x09 with no reads -> FIFO holds 0x01..0x08, overrun=1, and reads return 0x01..0x08 in order. Repeat with rd_en asserted exactly on the ninth push cycle -> no overrun, 0x09 stored.
- resetn pulsed low during DATA of frame 0x77 while the FIFO holds 2 bytes -> outputs reset immediately. The next clean frame 0x12 is received correctly and is the only FIFO entry.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path and the SOC IO decode.
// Holds the receiver FSM state encodings, the IO register offsets, the
// status bit positions and a helper for the baud divisor.
package uart_rx_fifo_pkg;

    // Receiver FSM states (3-bit encoding, visible to debug/IO logic)
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // IO register byte offsets
    localparam int unsigned RX_DATA_OFF   = 0;
    localparam int unsigned RX_STATUS_OFF = 4;

    // RX status register bit positions
    localparam int unsigned STAT_VALID_BIT     = 0;
    localparam int unsigned STAT_FRAME_ERR_BIT = 1;
    localparam int unsigned STAT_OVERRUN_BIT   = 2;

    // System clocks per serial bit (integer division)
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Ports: clk, rst_n (async, active low), push/wdata, pop, head (entry at
// the read pointer, zero while empty), full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with byte FIFO for the femtoRV SOC IO bus.
// Ports: clk, resetn (async, active low), rxd (raw pad), rd_en (pop
// strobe), rd_data (FIFO head), rx_valid (FIFO not empty), frame_err and
// overrun (sticky), clr_flags (clears both sticky flags; a set wins).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_flags
);

    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);

    logic             sync1;
    logic             rxs;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             push_q;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchronizer; idles high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Frame recovery FSM; push_q pulses the cycle after a good stop bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (clr_flags) frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= CNT_W'(CPB/2 - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            cnt     <= CNT_W'(CPB - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rxs, shreg[7:1]};
                        cnt     <= CNT_W'(CPB - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            push_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO is never empty, so a pop is possible iff rd_en is high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else begin
            if (clr_flags) overrun <= 1'b0;
            if (push_q && fifo_full && !rd_en) overrun <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push_q),
        .wdata (shreg),
        .pop   (rd_en),
        .head  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned CPB    = 16;
    localparam int unsigned DEPTH  = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic       rd_en;
    logic       clr_flags;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int         lat;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_flags (clr_flags)
    );

    // Monitor: every accepted pop is compared against the scoreboard
    always @(negedge clk) begin
        if (resetn && rd_en && rx_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%02h, scoreboard empty", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%02h expected 0x%02h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        while (!rx_valid && n < bound) begin
            tick(1);
            n++;
        end
        check(name, int'(rx_valid), 1);
    endtask

    task automatic read_one(input string name);
        wait_valid(40, name);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        rxd       = 1'b1;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        #2;
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        tick(3);
        resetn = 1'b1;
        tick(5);

        // Single frame with latency measurement
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    tick(1);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 155 || lat > 157) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 155..157", lat);
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("single_empty_after_pop", int'(rx_valid), 0);

        // Back-to-back frames
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        tick(4);
        for (int i = 0; i < 3; i++) read_one("b2b_valid");
        check("b2b_empty", int'(rx_valid), 0);
        check("b2b_frame_err", int'(frame_err), 0);
        check("b2b_overrun", int'(overrun), 0);

        // Short glitch is rejected, then a clean frame still decodes
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        check("glitch_no_push", int'(rx_valid), 0);
        check("glitch_frame_err", int'(frame_err), 0);
        check("glitch_overrun", int'(overrun), 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        read_one("glitch_recover_valid");

        // Stop bit low followed by a long break
        send_byte(8'h55, 1'b0);
        check("break_frame_err", int'(frame_err), 1);
        check("break_no_push", int'(rx_valid), 0);
        tick(40 * CPB);
        check("break_hold_err", int'(frame_err), 1);
        check("break_hold_no_push", int'(rx_valid), 0);
        pulse_clr();
        check("break_clr_err", int'(frame_err), 0);
        tick(4 * CPB);
        check("break_single_err", int'(frame_err), 0);
        rxd = 1'b1;
        tick(3 * CPB);
        check("break_release_err", int'(frame_err), 0);
        check("break_release_no_push", int'(rx_valid), 0);
        check("break_overrun", int'(overrun), 0);

        // Nine frames without reads: ninth byte dropped
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("ovr_flag_set", int'(overrun), 1);
        check("ovr_head", int'(rd_data), 8'h01);
        for (int i = 0; i < 8; i++) read_one("ovr_read_valid");
        check("ovr_drained", int'(rx_valid), 0);
        pulse_clr();
        check("ovr_clr", int'(overrun), 0);

        // Nine frames with a pop coinciding with the ninth push
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("full_no_ovr_yet", int'(overrun), 0);
        exp_q.push_back(8'h09);
        fork
            send_byte(8'h09, 1'b1);
            begin
                tick(155);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        check("simul_no_ovr", int'(overrun), 0);
        check("simul_head", int'(rd_data), 8'h02);
        for (int i = 0; i < 8; i++) read_one("simul_read_valid");
        check("simul_drained", int'(rx_valid), 0);

        // Reset mid-frame while the FIFO holds two bytes
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(2);
        check("prerst_valid", int'(rx_valid), 1);
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(3 * CPB);
        resetn = 1'b0;
        #1;
        check("midrst_rx_valid", int'(rx_valid), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        tick(2);
        resetn = 1'b1;
        tick(2 * CPB);
        check("postrst_empty", int'(rx_valid), 0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        read_one("postrst_valid");
        check("postrst_only_entry", int'(rx_valid), 0);
        check("postrst_frame_err", int'(frame_err), 0);

        tick(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
